// File: rtl/load_extract_unit_if.sv
// -----------------------------------------------------------------------------
// load_extract_unit_if
//
// Purpose:
//   Read channel between the load extract unit and data memory. The unit
//   raises a one-cycle request with a doubleword-aligned address. Memory
//   answers later with a single-cycle valid pulse carrying the 64-bit
//   little-endian doubleword.
//
// Signals:
//   mem_req     unit -> memory  read request (one cycle per load)
//   mem_addr    unit -> memory  doubleword-aligned read address
//   mem_rvalid  memory -> unit  read data valid, one-cycle pulse
//   mem_rdata   memory -> unit  read doubleword, little-endian
//
// Modports:
//   master  the load extract unit
//   slave   the data memory (or a testbench model of it)
// -----------------------------------------------------------------------------
interface load_extract_unit_if #(
   parameter int ADDR_W = 64
);
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rvalid;
   logic [63:0]       mem_rdata;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_rvalid,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_rvalid,
      output mem_rdata
   );
endinterface

// File: rtl/load_extract_unit.sv
// -----------------------------------------------------------------------------
// load_extract_unit
//
// Purpose:
//   Load-side data path of the multicycle RV64I core. On a load instruction
//   the unit fetches the containing doubleword from data memory. It then
//   extracts the addressed byte/half/word/doubleword lane and sign- or
//   zero-extends it to 64 bits. The result is registered for the write-back
//   mux, together with a one-cycle done pulse.
//
// Parameters:
//   TIMEOUT_CYCLES  cycles spent in WAIT before the read is abandoned (1..255)
//   ADDR_W          address width
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   start      in   one-cycle pulse from the control FSM: begin load
//   instr      in   instruction register ([6:0] opcode, [14:12] funct3)
//   addr       in   effective address, sampled with start
//   mem        if   read channel to data memory (master side)
//   load_data  out  extended load result, stable until the next start
//   done       out  one-cycle pulse when load_data is updated
//   busy       out  high whenever the FSM is outside IDLE
//   err        out  sticky until the next accepted start: timeout,
//                   illegal funct3 or (optionally) misaligned access
//
// Configuration:
//   LOAD_MISALIGN_TRAP_EN  when defined, misaligned half/word/double accesses
//                          are rejected with err=1 and no memory request.
//                          When undefined, the low offset bits below the
//                          access size are forced to zero and the load runs
//                          normally.
//
// Timing:
//   The lane is extracted while the doubleword is captured. load_data and
//   done are therefore both visible in the FMT cycle. Start-to-done latency
//   is 3 + N cycles, where N counts the WAIT cycles that pass without rvalid.
// -----------------------------------------------------------------------------
module load_extract_unit #(
   parameter int TIMEOUT_CYCLES = 15,
   parameter int ADDR_W         = 64
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic [31:0]         instr,
   input  logic [ADDR_W-1:0]   addr,
   load_extract_unit_if.master mem,
   output logic [63:0]         load_data,
   output logic                done,
   output logic                busy,
   output logic                err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_FMT
   } state_e;

   localparam logic [6:0] OPC_LOAD     = 7'b000_0011;
   localparam logic [2:0] F3_ILLEGAL   = 3'd7;
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_e            state_q,     state_d;
   logic [2:0]        funct3_q,    funct3_d;
   logic [2:0]        off_q,       off_d;
   logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   logic [7:0]        wait_cnt_q,  wait_cnt_d;
   logic [63:0]       load_data_q, load_data_d;
   logic              done_q,      done_d;
   logic              err_q,       err_d;

   // ---------------------------------------------------------------------------
   // Decode of the incoming instruction
   // ---------------------------------------------------------------------------
   logic       is_load;
   logic [2:0] start_f3;
   logic       misaligned;
   logic       unused_instr_bits;

   assign is_load  = (instr[6:0] == OPC_LOAD);
   assign start_f3 = instr[14:12];

   // Only opcode and funct3 matter here; the remaining fields are ignored.
   assign unused_instr_bits = ^{instr[31:15], instr[11:7]};

`ifdef LOAD_MISALIGN_TRAP_EN
   // funct3[1:0] encodes the access size (0 byte, 1 half, 2 word, 3 double).
   // The illegal funct3 (7) is also size 3 but is rejected earlier.
   assign misaligned = ((start_f3[1:0] == 2'd1) && (addr[0]   != 1'b0))  ||
                       ((start_f3[1:0] == 2'd2) && (addr[1:0] != 2'b00)) ||
                       ((start_f3[1:0] == 2'd3) && (addr[2:0] != 3'b000));
`else
   assign misaligned = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------------

   // Clear the offset bits below the access size. The lane then never
   // crosses the doubleword boundary. With the trap enabled this is a
   // no-op, because misaligned accesses never reach the memory.
   function automatic logic [2:0] align_off(input logic [2:0] f3,
                                            input logic [2:0] off);
      logic [2:0] res;
      case (f3[1:0])
         2'd1:    res = {off[2:1], 1'b0};
         2'd2:    res = {off[2], 2'b00};
         2'd3:    res = 3'b000;
         default: res = off;
      endcase
      return res;
   endfunction

   // Select the lane that starts at byte 'off' of a little-endian
   // doubleword, then extend it according to funct3.
   function automatic logic [63:0] extract(input logic [2:0]  f3,
                                           input logic [2:0]  off,
                                           input logic [63:0] dw);
      logic [63:0] lane;
      logic [63:0] res;
      lane = dw >> {off, 3'b000};
      case (f3)
         3'd0:    res = {{56{lane[7]}},  lane[7:0]};   // lb
         3'd1:    res = {{48{lane[15]}}, lane[15:0]};  // lh
         3'd2:    res = {{32{lane[31]}}, lane[31:0]};  // lw
         3'd3:    res = dw;                            // ld
         3'd4:    res = {56'd0, lane[7:0]};            // lbu
         3'd5:    res = {48'd0, lane[15:0]};           // lhu
         3'd6:    res = {32'd0, lane[31:0]};           // lwu
         default: res = 64'd0;
      endcase
      return res;
   endfunction

   // ---------------------------------------------------------------------------
   // Next-state and output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before the case statement, so no
      // path leaves one unassigned and no latch can be inferred.
      state_d     = state_q;
      funct3_d    = funct3_q;
      off_d       = off_q;
      mem_addr_d  = mem_addr_q;
      wait_cnt_d  = wait_cnt_q;
      load_data_d = load_data_q;
      done_d      = 1'b0;
      err_d       = err_q;

      case (state_q)
         S_IDLE: begin
            // Instructions that are not loads are ignored entirely.
            if (start && is_load) begin
               if ((start_f3 == F3_ILLEGAL) || misaligned) begin
                  // Rejected load: report it without touching memory.
                  err_d       = 1'b1;
                  load_data_d = 64'd0;
                  done_d      = 1'b1;
               end else begin
                  funct3_d   = start_f3;
                  off_d      = align_off(start_f3, addr[2:0]);
                  mem_addr_d = {addr[ADDR_W-1:3], 3'b000};
                  err_d      = 1'b0;
                  state_d    = S_REQ;
               end
            end
         end

         S_REQ: begin
            wait_cnt_d = 8'd0;
            state_d    = S_WAIT;
         end

         S_WAIT: begin
            // rvalid is tested first, so a response arriving in the expiry
            // cycle still completes the load cleanly.
            if (mem.mem_rvalid) begin
               load_data_d = extract(funct3_q, off_q, mem.mem_rdata);
               done_d      = 1'b1;
               state_d     = S_FMT;
            end else if (wait_cnt_q == TIMEOUT_LAST) begin
               err_d       = 1'b1;
               load_data_d = 64'd0;
               done_d      = 1'b1;
               state_d     = S_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end

         S_FMT: begin
            // load_data/done are presented during this cycle; a new start
            // is still ignored here because busy is high.
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         funct3_q    <= 3'd0;
         off_q       <= 3'd0;
         mem_addr_q  <= '0;
         wait_cnt_q  <= 8'd0;
         load_data_q <= 64'd0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every flop sample the values
         // from before the edge, whatever order the statements appear in.
         state_q     <= state_d;
         funct3_q    <= funct3_d;
         off_q       <= off_d;
         mem_addr_q  <= mem_addr_d;
         wait_cnt_q  <= wait_cnt_d;
         load_data_q <= load_data_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign mem.mem_req  = (state_q == S_REQ);
   assign mem.mem_addr = mem_addr_q;
   assign load_data    = load_data_q;
   assign done         = done_q;
   assign busy         = (state_q != S_IDLE);
   assign err          = err_q;

endmodule
